// File: rtl/i2c_cfg_arbiter_pkg.sv
// Shared constants for the I2C configuration path: transfer width and arbiter state encodings.
// Also used by the config sequencers; no logic, no latency, no flow control.
package i2c_cfg_arbiter_pkg;

    localparam int XFER_W = 24;
    localparam int PTR_W  = 2;
    localparam int TMR_W  = 12;
    localparam int RTY_W  = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_BUSY  = 3'd2;
    localparam logic [2:0] ST_OK    = 3'd3;
    localparam logic [2:0] ST_FAIL  = 3'd4;

endpackage

// File: rtl/i2c_rr_pick.sv
// Round-robin pick: first requester after last_i (wrapping); combinational, zero latency.
// No backpressure: a pure function of the request vector and pointer.
module i2c_rr_pick
    import i2c_cfg_arbiter_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] last_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] idx_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req_i[i] && (i == ((int'(last_i) + k) % N_REQ))) begin
                    found    = 1'b1;
                    gnt_o[i] = 1'b1;
                    idx_o    = PTR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/i2c_cfg_arbiter.sv
// Round-robin share of one I2C controller; grant 1 cycle after request, done 1 cycle after END.
// Requesters hold iREQ until oDONE; one transfer outstanding, NACK retry and per-phase timeout.
module i2c_cfg_arbiter
    import i2c_cfg_arbiter_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT   = 4095
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic [N_REQ-1:0]        iREQ,
    input  logic [XFER_W*N_REQ-1:0] iREQ_DATA,
    output logic [N_REQ-1:0]        oDONE,
    output logic [N_REQ-1:0]        oERR,
    output logic [N_REQ-1:0]        oGNT,
    output logic [XFER_W-1:0]       oI2C_DATA,
    output logic                    oI2C_GO,
    input  logic                    iI2C_END,
    input  logic                    iI2C_ACK
);

    logic [2:0]        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [PTR_W-1:0]  idx_q, idx_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [XFER_W-1:0] data_q, data_d;
    logic              go_q, go_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic [N_REQ-1:0]  pick_gnt;
    logic [PTR_W-1:0]  pick_idx;
    logic [XFER_W-1:0] pick_dat;
    logic              tmo_hit;

    i2c_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i  (iREQ),
        .last_i (ptr_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

    always_comb begin
        pick_dat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == PTR_W'(i)) pick_dat = iREQ_DATA[i*XFER_W +: XFER_W];
        end
    end

    assign tmo_hit = (timer_q == TMR_W'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        go_d    = go_q;
        retry_d = retry_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (|iREQ) begin
                    state_d = ST_START;
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                    data_d  = pick_dat;
                    timer_d = '0;
                end
            end
            // END must be seen low first so a stale END from the last transfer is not taken as completion
            ST_START: begin
                if (!iI2C_END) begin
                    state_d = ST_BUSY;
                    go_d    = 1'b1;
                    timer_d = '0;
                end else if (tmo_hit) begin
                    state_d = ST_FAIL;
                    go_d    = 1'b0;
                end else begin
                    go_d    = 1'b1;
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_BUSY: begin
                if (iI2C_END) begin
                    go_d = 1'b0;
                    if (!iI2C_ACK) begin
                        state_d = ST_OK;
                    end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                        state_d = ST_START;
                        retry_d = retry_q + 1'b1;
                        timer_d = '0;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_FAIL;
                    go_d    = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_OK, ST_FAIL: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                go_d    = 1'b0;
                ptr_d   = idx_q;
                retry_d = '0;
                timer_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                go_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= PTR_W'(N_REQ - 1);
            data_q  <= '0;
            go_q    <= 1'b0;
            retry_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            go_q    <= go_d;
            retry_q <= retry_d;
            timer_q <= timer_d;
        end
    end

    assign oGNT      = gnt_q;
    assign oI2C_DATA = data_q;
    assign oI2C_GO   = go_q;
    assign oDONE     = ((state_q == ST_OK) || (state_q == ST_FAIL)) ? gnt_q : '0;
    assign oERR      = (state_q == ST_FAIL) ? gnt_q : '0;

endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// Directed bench for i2c_cfg_arbiter with a small behavioural I2C controller model.
module tb_i2c_cfg_arbiter;

    localparam int TIMEOUT = 4095;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic [1:0]  iREQ;
    logic [47:0] iREQ_DATA;
    logic [1:0]  oDONE, oERR, oGNT;
    logic [23:0] oI2C_DATA;
    logic        oI2C_GO;
    logic        iI2C_END, iI2C_ACK;

    always #5 iCLK = ~iCLK;

    i2c_cfg_arbiter #(.N_REQ(2), .MAX_RETRY(2), .TIMEOUT(TIMEOUT)) dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iREQ      (iREQ),
        .iREQ_DATA (iREQ_DATA),
        .oDONE     (oDONE),
        .oERR      (oERR),
        .oGNT      (oGNT),
        .oI2C_DATA (oI2C_DATA),
        .oI2C_GO   (oI2C_GO),
        .iI2C_END  (iI2C_END),
        .iI2C_ACK  (iI2C_ACK)
    );

    // Controller model: clears END m_clr_dly cycles after seeing GO, raises END 4 cycles later
    bit m_hang = 1'b0;
    int m_clr_dly = 0;
    int m_st, m_cnt;
    bit ack_q[$];

    always @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            iI2C_END <= 1'b1;
            iI2C_ACK <= 1'b0;
            m_st     <= 0;
            m_cnt    <= 0;
        end else begin
            case (m_st)
                0: if (oI2C_GO) begin
                    if (m_cnt == m_clr_dly) begin
                        iI2C_END <= 1'b0;
                        m_st     <= 1;
                        m_cnt    <= 0;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
                1: if (!m_hang) begin
                    if (m_cnt == 3) begin
                        iI2C_END <= 1'b1;
                        if (ack_q.size() > 0) iI2C_ACK <= ack_q.pop_front();
                        else                  iI2C_ACK <= 1'b0;
                        m_st <= 2;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
                default: if (!oI2C_GO) begin
                    m_st  <= 0;
                    m_cnt <= 0;
                end
            endcase
        end
    end

    int          go_rises = 0;
    logic        go_prev = 1'b0;
    logic [23:0] go_dat_q[$];

    always @(posedge iCLK) begin
        go_prev <= oI2C_GO;
        if (oI2C_GO && !go_prev) begin
            go_rises <= go_rises + 1;
            go_dat_q.push_back(oI2C_DATA);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            @(negedge iCLK);
            cyc++;
            if (oDONE != 2'b00) ok = 1'b1;
        end
    endtask

    task automatic wait_gnt(input int budget, output bit ok);
        int cyc;
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            @(negedge iCLK);
            cyc++;
            if (oGNT != 2'b00) ok = 1'b1;
        end
    endtask

    initial begin
        int          cyc, g0, stale;
        bit          ok, early;
        logic [1:0]  exp_g;
        logic [23:0] exp_d;

        iRST_N    = 1'b0;
        iREQ      = 2'b00;
        iREQ_DATA = '0;
        repeat (2) @(negedge iCLK);
        chk("rst_gnt",  32'(oGNT), 32'h0);
        chk("rst_go",   32'(oI2C_GO), 32'h0);
        chk("rst_done", 32'(oDONE), 32'h0);
        chk("rst_err",  32'(oERR), 32'h0);
        chk("rst_data", 32'(oI2C_DATA), 32'h0);
        iRST_N = 1'b1;
        @(negedge iCLK);

        // Contention from reset: requester 0 first, then strict alternation
        iREQ_DATA = {24'h34001A, 24'h4A0200};
        iREQ      = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (t % 2 == 0) ? 24'h4A0200 : 24'h34001A;
            wait_gnt(10, ok);
            chk("cont_gnt_seen", 32'(ok), 32'h1);
            chk("cont_gnt",  32'(oGNT), 32'(exp_g));
            chk("cont_data", 32'(oI2C_DATA), 32'(exp_d));
            wait_done(60, cyc, ok);
            chk("cont_done_seen", 32'(ok), 32'h1);
            chk("cont_done", 32'(oDONE), 32'(exp_g));
            chk("cont_err",  32'(oERR), 32'h0);
        end
        iREQ = 2'b00;
        repeat (2) @(negedge iCLK);

        // Single request, ACK=0
        g0 = go_rises;
        iREQ_DATA = {24'h34001A, 24'h4A0108};
        iREQ      = 2'b01;
        @(negedge iCLK);
        chk("single_gnt",  32'(oGNT), 32'h1);
        chk("single_data", 32'(oI2C_DATA), 32'h4A0108);
        chk("single_go_lat", 32'(oI2C_GO), 32'h0);
        @(negedge iCLK);
        chk("single_go", 32'(oI2C_GO), 32'h1);
        wait_done(60, cyc, ok);
        chk("single_done_seen", 32'(ok), 32'h1);
        chk("single_done", 32'(oDONE), 32'h1);
        chk("single_err",  32'(oERR), 32'h0);
        chk("single_go_off", 32'(oI2C_GO), 32'h0);
        iREQ = 2'b00;
        @(negedge iCLK);
        chk("single_pulse_1cyc", 32'(oDONE), 32'h0);
        chk("single_gnt_clr", 32'(oGNT), 32'h0);
        chk("single_go_pulses", 32'(go_rises - g0), 32'h1);
        @(negedge iCLK);

        // NACK twice then ACK: three attempts with data frozen at grant
        ack_q.push_back(1'b1);
        ack_q.push_back(1'b1);
        ack_q.push_back(1'b0);
        go_dat_q.delete();
        g0 = go_rises;
        iREQ_DATA[23:0] = 24'h4A0310;
        iREQ            = 2'b01;
        @(negedge iCLK);
        chk("retry_gnt", 32'(oGNT), 32'h1);
        iREQ_DATA[23:0] = 24'hFFFFFF;
        wait_done(120, cyc, ok);
        chk("retry_done_seen", 32'(ok), 32'h1);
        chk("retry_done", 32'(oDONE), 32'h1);
        chk("retry_err",  32'(oERR), 32'h0);
        chk("retry_data_held", 32'(oI2C_DATA), 32'h4A0310);
        chk("retry_go_pulses", 32'(go_rises - g0), 32'h3);
        chk("retry_dat_cnt", 32'(go_dat_q.size()), 32'h3);
        for (int i = 0; i < 3; i++) begin
            if (i < go_dat_q.size()) chk("retry_dat_each", 32'(go_dat_q[i]), 32'h4A0310);
        end
        iREQ = 2'b00;
        repeat (2) @(negedge iCLK);

        // NACK on every attempt from requester 1: error after the third
        ack_q.push_back(1'b1);
        ack_q.push_back(1'b1);
        ack_q.push_back(1'b1);
        g0 = go_rises;
        iREQ_DATA[47:24] = 24'h34005C;
        iREQ             = 2'b10;
        wait_gnt(10, ok);
        chk("nack_gnt", 32'(oGNT), 32'h2);
        chk("nack_data", 32'(oI2C_DATA), 32'h34005C);
        wait_done(120, cyc, ok);
        chk("nack_done_seen", 32'(ok), 32'h1);
        chk("nack_done", 32'(oDONE), 32'h2);
        chk("nack_err",  32'(oERR), 32'h2);
        chk("nack_go_pulses", 32'(go_rises - g0), 32'h3);
        chk("nack_acks_used", 32'(ack_q.size()), 32'h0);
        iREQ = 2'b00;
        repeat (2) @(negedge iCLK);

        // Stale END: controller keeps END high for 5 extra cycles after GO
        m_clr_dly = 5;
        g0 = go_rises;
        iREQ_DATA[23:0] = 24'h4A0412;
        iREQ            = 2'b01;
        wait_gnt(10, ok);
        chk("stale_gnt", 32'(oGNT), 32'h1);
        early = 1'b0;
        stale = 0;
        while (iI2C_END && stale < 30) begin
            @(negedge iCLK);
            stale++;
            if (oDONE != 2'b00) early = 1'b1;
        end
        chk("stale_no_early_done", 32'(early), 32'h0);
        chk("stale_end_cleared", 32'(iI2C_END), 32'h0);
        chk("stale_go_held", 32'(oI2C_GO), 32'h1);
        wait_done(60, cyc, ok);
        chk("stale_done", 32'(oDONE), 32'h1);
        chk("stale_err",  32'(oERR), 32'h0);
        chk("stale_go_pulses", 32'(go_rises - g0), 32'h1);
        iREQ      = 2'b00;
        m_clr_dly = 0;
        repeat (2) @(negedge iCLK);

        // Timeout in BUSY: END never rises again
        m_hang = 1'b1;
        iREQ   = 2'b01;
        wait_gnt(10, ok);
        chk("tmo_gnt", 32'(oGNT), 32'h1);
        stale = 0;
        while (iI2C_END && stale < 20) begin
            @(negedge iCLK);
            stale++;
        end
        // one cycle for START to see END low, then TIMEOUT+1 cycles in BUSY
        wait_done(TIMEOUT + 20, cyc, ok);
        chk("tmo_done_seen", 32'(ok), 32'h1);
        chk("tmo_cycles", 32'(cyc), 32'(TIMEOUT + 2));
        chk("tmo_done", 32'(oDONE), 32'h1);
        chk("tmo_err",  32'(oERR), 32'h1);
        chk("tmo_go_off", 32'(oI2C_GO), 32'h0);
        iREQ = 2'b00;
        @(negedge iCLK);
        chk("tmo_go_after", 32'(oI2C_GO), 32'h0);
        @(negedge iCLK);

        // Reset while BUSY (model still hung); pointer says requester 1 is next
        iREQ = 2'b11;
        wait_gnt(10, ok);
        chk("rb_gnt", 32'(oGNT), 32'h2);
        repeat (4) @(negedge iCLK);
        chk("rb_go_busy", 32'(oI2C_GO), 32'h1);
        #2 iRST_N = 1'b0;
        #1;
        chk("rb_gnt_clr",  32'(oGNT), 32'h0);
        chk("rb_go_clr",   32'(oI2C_GO), 32'h0);
        chk("rb_data_clr", 32'(oI2C_DATA), 32'h0);
        chk("rb_done_clr", 32'(oDONE), 32'h0);
        chk("rb_err_clr",  32'(oERR), 32'h0);
        m_hang = 1'b0;
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        wait_gnt(10, ok);
        chk("rb_first_gnt", 32'(oGNT), 32'h1);
        chk("rb_first_data", 32'(oI2C_DATA), 32'h4A0412);
        wait_done(60, cyc, ok);
        chk("rb_done", 32'(oDONE), 32'h1);
        chk("rb_err",  32'(oERR), 32'h0);
        iREQ = 2'b00;
        repeat (3) @(negedge iCLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
